// File: rtl/logic_accum_unit.sv
// logic_accum_unit: registered bitwise logic unit with valid/ready handshakes
// on both sides, an optional accumulator used as operand B with write-back,
// and result flags (parity, zero, population count) registered alongside y.
module logic_accum_unit #(
   parameter int WIDTH = 16,
   parameter int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             acc_mode,
   input  logic             acc_clr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             parity,
   output logic             zero,
   output logic [CW-1:0]    ones
);

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_XOR  = 3'b010;
   localparam logic [2:0] OP_NAND = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_XNOR = 3'b101;
   localparam logic [2:0] OP_NOTA = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   logic             out_valid_reg;
   logic [WIDTH-1:0] y_reg;
   logic             parity_reg;
   logic             zero_reg;
   logic [CW-1:0]    ones_reg;
   logic [WIDTH-1:0] acc_reg;

   logic             in_xfer;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] result_next;
   logic             parity_next;
   logic             zero_next;
   logic [CW-1:0]    ones_next;

   // The stage can take a new operand set when it is empty or its current
   // result leaves this same cycle; depends only on state and out_ready.
   assign in_ready = !out_valid_reg || out_ready;
   assign in_xfer  = in_valid && in_ready;

   // Operand B comes from the accumulator in accumulate mode. The value used
   // is the register content before any clear at this edge.
   assign opb = acc_mode ? acc_reg : b;

   // One bitwise slice per result bit; all ops are purely per-bit.
   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
         // Per-bit operation select
         always_comb begin
            result_next[gi] = 1'b0;
            case (op)
               OP_AND:  result_next[gi] =   a[gi] & opb[gi];
               OP_OR:   result_next[gi] =   a[gi] | opb[gi];
               OP_XOR:  result_next[gi] =   a[gi] ^ opb[gi];
               OP_NAND: result_next[gi] = ~(a[gi] & opb[gi]);
               OP_NOR:  result_next[gi] = ~(a[gi] | opb[gi]);
               OP_XNOR: result_next[gi] = ~(a[gi] ^ opb[gi]);
               OP_NOTA: result_next[gi] =  ~a[gi];
               OP_PASS: result_next[gi] =   a[gi];
               default: result_next[gi] = 1'b0;
            endcase
         end
      end
   endgenerate

   // Flags are computed from the next result so they can be registered in
   // lockstep with y and never disagree with it.
   always_comb begin
      parity_next = ^result_next;
      zero_next   = (result_next == '0);
      ones_next   = '0;
      for (int i = 0; i < WIDTH; i++) begin
         ones_next = ones_next + CW'(result_next[i]);
      end
   end

   // Output stage: load on input transfer, otherwise drop valid once taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         y_reg         <= '0;
         parity_reg    <= 1'b0;
         zero_reg      <= 1'b1;
         ones_reg      <= '0;
      end else if (in_xfer) begin
         out_valid_reg <= 1'b1;
         y_reg         <= result_next;
         parity_reg    <= parity_next;
         zero_reg      <= zero_next;
         ones_reg      <= ones_next;
      end else if (out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // Accumulator: clear wins over write-back; plain-mode transfers leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
      end else if (acc_clr) begin
         acc_reg <= '0;
      end else if (in_xfer && acc_mode) begin
         acc_reg <= result_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign y         = y_reg;
   assign parity    = parity_reg;
   assign zero      = zero_reg;
   assign ones      = ones_reg;

endmodule

// File: doc/logic_accum_unit.md
LOGIC_ACCUM_UNIT -- requirements
Module: logic_accum_unit

Interface
REQ-001 Parameter WIDTH, default 16, operand/result width in bits; legal range 2..64.
REQ-002 Parameter CW, default $clog2(WIDTH+1), width of the ones-count output.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  unit can accept an operand set this cycle.
REQ-007 op  input  3  operation select: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT a, 111 pass a.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B; ignored when acc_mode=1.
REQ-010 acc_mode  input  1  1 = use accumulator as operand B and write result back to the accumulator.
REQ-011 acc_clr  input  1  synchronous accumulator clear request.
REQ-012 out_valid  output  1  result registers hold an undelivered result.
REQ-013 out_ready  input  1  consumer accepts the result this cycle.
REQ-014 y  output  WIDTH  registered result.
REQ-015 parity  output  1  XOR-reduction of y.
REQ-016 zero  output  1  1 when y is all zeros.
REQ-017 ones  output  CW  population count of y.

Function
REQ-018 Input transfer occurs on a clock edge with in_valid=1 and in_ready=1; output transfer on an edge with out_valid=1 and out_ready=1.
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally; no combinational path from in_valid to in_ready.
REQ-020 Latency: result of an input transfer SHALL appear on y/flags with out_valid=1 the following cycle (one register stage).
REQ-021 On input transfer, y/parity/zero/ones SHALL load the result and its flags computed from a, the selected operand B, and op, all sampled at that edge.
REQ-022 Without an input transfer, out_valid SHALL clear on an output transfer, otherwise hold; y and flags SHALL hold whenever no input transfer occurs.
REQ-023 Simultaneous output and input transfer SHALL load the new result with out_valid remaining 1 (full throughput, one result per cycle).
REQ-024 Flags SHALL be registered with y and always consistent with the current y.
REQ-025 Accumulator acc is WIDTH bits; on input transfer with acc_mode=1 acc SHALL load the computed result.
REQ-026 acc_clr=1 SHALL set acc to zero at the edge, independent of handshakes, and takes priority over any write-back in the same cycle; an operation accepted in that cycle uses the pre-clear acc value.
REQ-027 Input transfers with acc_mode=0 SHALL NOT modify acc.
REQ-028 op values 110 and 111 ignore operand B in both modes; acc write-back still applies when acc_mode=1.
REQ-029 All results are bitwise at WIDTH bits; no carry, no sign extension.
REQ-030 in_valid=1 while in_ready=0 SHALL NOT be accepted; the producer holds inputs stable until transfer.

Reset
REQ-031 While rst_n=0, out_valid=0, y=0, parity=0, zero=1, ones=0, acc=0, regardless of clk.
REQ-032 Reset asserted mid-operation SHALL discard the pending result and accumulator contents immediately; in_ready=1 after release.
REQ-033 First input transfer is possible on the first rising edge after rst_n deasserts.

Verification (WIDTH=16)
REQ-034 Check after reset: out_valid=0, y=0x0000, zero=1, ones=0, in_ready=1.
REQ-035 Check XOR: op=010, a=0x4648, b=0x1082, out_ready=1 -> next cycle y=0x56CA, ones=8, parity=0, zero=0.
REQ-036 Check cancellation: op=010, a=b=0x1082 -> y=0x0000, zero=1, parity=0; op=011, a=b=0xFFFF -> y=0x0000.
REQ-037 Check accumulation: acc_clr pulse, then acc_mode=1 op=010 a=0x00FF -> y=0x00FF; next a=0x0F0F -> y=0x0FF0, ones=8; acc_clr with simultaneous acc_mode transfer a=0x0001 -> y=0x0FF1, following a=0x0001 -> y=0x0001.
REQ-038 Check backpressure: out_ready=0, two back-to-back in_valid beats -> first accepted, in_ready=0, y stable for 5 cycles; raise out_ready -> second beat accepted same edge, no loss or duplication.
REQ-039 Check reset mid-operation: rst_n low with out_valid=1 and acc=0x00FF -> out_valid=0, y=0 without a clock edge; after release, acc_mode XOR a=0x0003 -> y=0x0003.
